audio_i2s_tx: RTL and testbench

Serial transmitter that takes the signed 16-bit stereo mix produced by the audio mixer (`audio_l`/`audio_r`) and drives an external I2S DAC. It generates BCLK and LRCK from the system clock and shifts both channels out MSB-first in standard Philips I2S framing, with a one-BCLK data delay after each LRCK edge. Both channels are captured together once per frame, and a strobe is issued at each capture.

---
 rtl/audio_i2s_tx.sv | 116 +++++++++++
 tb/tb_audio_i2s_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
// Philips I2S transmitter for a signed 16-bit stereo pair. BCLK and LRCK are
// derived from clk by a half-period divider. Both channels are captured at the
// start of every 32-slot frame and shifted out MSB-first. LRCK leads each word
// by one BCLK.
//
// Parameters:
//   BCLK_HALF  clk cycles per BCLK half-period (>= 1)
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   audio_l    in   16-bit signed left sample
//   audio_r    in   16-bit signed right sample
//   mute       in   load zeros instead of samples at capture
//   i2s_bclk   out  bit clock (DAC samples on its rising edge)
//   i2s_lrck   out  word select, 0 = left, 1 = right
//   i2s_data   out  serial data, changes only on BCLK falling edges
//   sample_req out  one-clk pulse when a new L/R pair is captured
// -----------------------------------------------------------------------------
module audio_i2s_tx #(
  parameter int BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        sample_req
);

  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CW-1:0] DIV_TC = CW'(BCLK_HALF - 1);

  logic [CW-1:0] div_cnt_r;
  logic          bclk_r;
  logic          lrck_r;
  logic          data_r;
  logic          req_r;
  logic [4:0]    slot_r;
  logic [31:0]   sh_r;

  logic [CW-1:0] div_nxt_s;
  logic          bclk_nxt_s;
  logic          lrck_nxt_s;
  logic          data_nxt_s;
  logic          req_nxt_s;
  logic [4:0]    slot_nxt_s;
  logic [31:0]   sh_nxt_s;

  // Next-state: divider, slot advance on BCLK fall, capture and serial outputs.
  always_comb begin
    div_nxt_s  = div_cnt_r + CW'(1);
    bclk_nxt_s = bclk_r;
    lrck_nxt_s = lrck_r;
    data_nxt_s = data_r;
    req_nxt_s  = 1'b0;
    slot_nxt_s = slot_r;
    sh_nxt_s   = sh_r;
    if (div_cnt_r == DIV_TC) begin
      div_nxt_s  = '0;
      bclk_nxt_s = ~bclk_r;
      if (bclk_r) begin
        // Fall event: step into the next slot.
        slot_nxt_s = slot_r + 5'd1;
        if (slot_nxt_s == 5'd0) begin
          sh_nxt_s  = mute ? 32'h0000_0000 : {audio_l, audio_r};
          req_nxt_s = 1'b1;
        end else begin
          sh_nxt_s  = sh_r;
          req_nxt_s = 1'b0;
        end
        // Slot s carries sh[31-s]; slot 0 uses the freshly captured word.
        data_nxt_s = sh_nxt_s[~slot_nxt_s];
        // LRCK leads each word's MSB by one slot.
        lrck_nxt_s = (slot_nxt_s >= 5'd15) && (slot_nxt_s <= 5'd30);
      end else begin
        slot_nxt_s = slot_r;
        data_nxt_s = data_r;
        lrck_nxt_s = lrck_r;
      end
    end else begin
      bclk_nxt_s = bclk_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
      bclk_r    <= 1'b0;
      lrck_r    <= 1'b0;
      data_r    <= 1'b0;
      req_r     <= 1'b0;
      slot_r    <= 5'd31;
      sh_r      <= 32'h0000_0000;
    end else begin
      div_cnt_r <= div_nxt_s;
      bclk_r    <= bclk_nxt_s;
      lrck_r    <= lrck_nxt_s;
      data_r    <= data_nxt_s;
      req_r     <= req_nxt_s;
      slot_r    <= slot_nxt_s;
      sh_r      <= sh_nxt_s;
    end
  end

  assign i2s_bclk   = bclk_r;
  assign i2s_lrck   = lrck_r;
  assign i2s_data   = data_r;
  assign sample_req = req_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
// Three instances (BCLK_HALF = 4, 2, 1) share the stimulus inputs; each test
// observes one instance, decoding i2s_data on BCLK rising edges like a DAC.
// -----------------------------------------------------------------------------
module tb_audio_i2s_tx;

  logic        clk;
  logic        reset_n;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        mute;
  logic [2:0]  bclk;
  logic [2:0]  lrck;
  logic [2:0]  data;
  logic [2:0]  req;

  int n_pass;
  int n_total;

  // index 0: BCLK_HALF=4, index 1: BCLK_HALF=2, index 2: BCLK_HALF=1
  audio_i2s_tx #(.BCLK_HALF(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
    .mute(mute), .i2s_bclk(bclk[0]), .i2s_lrck(lrck[0]),
    .i2s_data(data[0]), .sample_req(req[0]));
  audio_i2s_tx #(.BCLK_HALF(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
    .mute(mute), .i2s_bclk(bclk[1]), .i2s_lrck(lrck[1]),
    .i2s_data(data[1]), .sample_req(req[1]));
  audio_i2s_tx #(.BCLK_HALF(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
    .mute(mute), .i2s_bclk(bclk[2]), .i2s_lrck(lrck[2]),
    .i2s_data(data[2]), .sample_req(req[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Wait (bounded) for a sample_req pulse of instance sel, observed at negedge.
  task automatic wait_req(input int sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (req[sel]) seen = 1'b1;
    end
    if (!seen) chk("wait_req_timeout", 32'd0, 32'd1);
  endtask

  // Decode one frame from the capture point; optionally change inputs after
  // the rising edge of slot chg_slot.
  task automatic capture_frame(input int sel, input int chg_slot,
                               input logic [15:0] chg_l, input logic chg_mute,
                               output logic [15:0] dl, output logic [15:0] dr,
                               output int lr_err);
    int   k;
    logic prev;
    logic exp_lr;
    k = 0; prev = bclk[sel]; dl = 16'h0; dr = 16'h0; lr_err = 0;
    for (int i = 0; i < 2000 && k < 32; i++) begin
      @(negedge clk);
      if (bclk[sel] && !prev) begin
        if (k < 16) dl = {dl[14:0], data[sel]};
        else        dr = {dr[14:0], data[sel]};
        exp_lr = (k >= 15) && (k <= 30);
        if (lrck[sel] !== exp_lr) lr_err++;
        if (k == chg_slot) begin
          audio_l = chg_l;
          mute    = chg_mute;
        end
        k++;
      end
      prev = bclk[sel];
    end
    if (k < 32) chk("frame_timeout", 32'(k), 32'd32);
  endtask

  initial begin
    logic [15:0] dl, dr;
    int lr_err;
    int first[3];
    int second[3];
    int third0;
    int bclk1_err;
    logic prev1;

    n_pass = 0; n_total = 0;
    vecs[0] = '{1, 16'h8001, 16'h7FFE, 1'b0, 16'h8001, 16'h7FFE};
    vecs[1] = '{2, 16'hA5C3, 16'h3C5A, 1'b0, 16'hA5C3, 16'h3C5A};
    vecs[2] = '{0, 16'h1234, 16'h5678, 1'b0, 16'h1234, 16'h5678};
    vecs[3] = '{0, 16'h5555, 16'h5555, 1'b1, 16'h0000, 16'h0000};
    vecs[4] = '{1, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
    vecs[5] = '{2, 16'h8000, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF};

    reset_n = 1'b0; audio_l = 16'h0; audio_r = 16'h0; mute = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);

    // Mid-frame asynchronous reset: outputs clear without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_bclk", 32'(bclk[0]), 32'd0);
    chk("rst_lrck", 32'(lrck[0]), 32'd0);
    chk("rst_data", 32'(data[0]), 32'd0);
    chk("rst_req",  32'(req[0]),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Post-reset timing of sample_req and BCLK_HALF=1 toggling.
    first = '{0, 0, 0}; second = '{0, 0, 0}; third0 = 0;
    bclk1_err = 0; prev1 = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      if (bclk[2] === prev1) bclk1_err++;
      prev1 = bclk[2];
      for (int s = 0; s < 3; s++) begin
        if (req[s]) begin
          if (first[s] == 0) first[s] = c;
          else if (second[s] == 0) second[s] = c;
          else if (s == 0 && third0 == 0) third0 = c;
        end
      end
    end
    chk("first_req_h4", 32'(first[0]), 32'd8);
    chk("first_req_h2", 32'(first[1]), 32'd4);
    chk("first_req_h1", 32'(first[2]), 32'd2);
    chk("req_period_h4_a", 32'(second[0] - first[0]), 32'd256);
    chk("req_period_h4_b", 32'(third0 - second[0]), 32'd256);
    chk("req_period_h2", 32'(second[1] - first[1]), 32'd128);
    chk("req_period_h1", 32'(second[2] - first[2]), 32'd64);
    chk("bclk_h1_toggle_err", 32'(bclk1_err), 32'd0);

    // Table-driven frames: inputs set one frame ahead of the checked frame.
    foreach (vecs[i]) begin
      wait_req(vecs[i].sel);
      audio_l = vecs[i].l; audio_r = vecs[i].r; mute = vecs[i].m;
      wait_req(vecs[i].sel);
      capture_frame(vecs[i].sel, -1, 16'h0, 1'b0, dl, dr, lr_err);
      chk($sformatf("vec%0d_left", i), 32'(dl), 32'(vecs[i].exp_l));
      chk($sformatf("vec%0d_right", i), 32'(dr), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d_lrck_err", i), 32'(lr_err), 32'd0);
    end

    // Capture isolation: left changes during slot 5 of a frame in flight.
    mute = 1'b0; audio_r = 16'h0000;
    wait_req(0);
    audio_l = 16'h1234;
    wait_req(0);
    capture_frame(0, 5, 16'hFFFF, 1'b0, dl, dr, lr_err);
    chk("iso_cur_left", 32'(dl), 32'h1234);
    chk("iso_cur_right", 32'(dr), 32'h0000);
    wait_req(0);
    capture_frame(0, -1, 16'h0, 1'b0, dl, dr, lr_err);
    chk("iso_next_left", 32'(dl), 32'hFFFF);

    // Mute: asserted at capture, dropped in slot 3.
    wait_req(0);
    audio_l = 16'h5555; audio_r = 16'h5555; mute = 1'b1;
    wait_req(0);
    capture_frame(0, 3, 16'h5555, 1'b0, dl, dr, lr_err);
    chk("mute_cur_left", 32'(dl), 32'h0000);
    chk("mute_cur_right", 32'(dr), 32'h0000);
    wait_req(0);
    capture_frame(0, -1, 16'h5555, 1'b0, dl, dr, lr_err);
    chk("mute_next_left", 32'(dl), 32'h5555);
    chk("mute_next_right", 32'(dr), 32'h5555);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
